diferenca_sad: RTL

- Parametrised, clocked successor of the 4-bit combinational magnitude/sign difference unit.
- Computes |A-B| and a sign flag per accepted sample pair, with a valid/ready input handshake and a registered output stage.
- Accumulates a sum of absolute differences (SAD) over a run of COUNT pairs and reports it with a one-cycle valid pulse.
- Sits between the operand source and the result display/compare logic.

---
 rtl/diferenca_sad.sv | 102 ++++++++++
 1 files changed

// File: rtl/diferenca_sad.sv
// Clocked |A-B| / sign unit with valid/ready input and a SAD accumulator over COUNT pairs.
// Build option: define SAD_SATURATE_EN to clamp sad at all-ones on overflow instead of wrapping.
module diferenca_sad #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned COUNT = 8,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             sinal,
  output logic             diff_valid,
  output logic [ACC_W-1:0] sad,
  output logic             sad_valid,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic             xfer;
  logic             run_start;
  logic             a_lt_b;
  logic [WIDTH-1:0] abs_ab;
  logic [ACC_W:0]   sum;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    run_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = RUN;
          run_start = 1'b1;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer = in_valid & in_ready;

  // Subtracting the smaller from the larger operand keeps the result exact in WIDTH bits.
  always_comb begin
    a_lt_b = (A < B);
    abs_ab = a_lt_b ? (B - A) : (A - B);
    sum    = {1'b0, sad} + (ACC_W + 1)'(S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      S          <= '0;
      sinal      <= 1'b0;
      diff_valid <= 1'b0;
      sad        <= '0;
      sad_valid  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      diff_valid <= xfer;
      sad_valid  <= (state == DONE);
      if (xfer) begin
        S     <= abs_ab;
        sinal <= a_lt_b;
        cnt   <= cnt + 8'd1;
      end
      if (run_start) begin
        cnt <= '0;
        sad <= '0;
        ovf <= 1'b0;
      end else if (diff_valid) begin
        ovf <= ovf | sum[ACC_W];
`ifdef SAD_SATURATE_EN
        sad <= (ovf || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
        sad <= sum[ACC_W-1:0];
`endif
      end
    end
  end

endmodule
